// File: rtl/gmii_udp_rx.sv
// gmii_udp_rx: Ethernet II / IPv4 / UDP receive parser on the GMII RX bus.
// Filters on local MAC/IP/port and streams the UDP payload bytes.
`default_nettype none

module gmii_udp_rx #(
  parameter logic [47:0] LOCAL_MAC  = 48'h06_00_AA_BB_0C_DD,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0002,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  GMII_RXD,
  input  logic        GMII_RXDV,
  input  logic        GMII_RXER,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [31:0] src_ip,
  output logic [15:0] src_port,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_WAIT_END
  } state_t;

  state_t      state;
  logic [15:0] byte_cnt;
  logic [15:0] remain;
  logic [39:0] shift_reg;
  logic [31:0] cap_src_ip;
  logic [15:0] cap_src_port;
  logic        rxdv_q;

  logic [15:0] word16;
  logic [31:0] word32;
  logic [47:0] word48;
  logic        in_hdr;
  logic        hdr_bad;
  logic        drop_event;

  // Multi-byte fields are compared on their last byte using the preceding bytes.
  assign word16 = {shift_reg[7:0], GMII_RXD};
  assign word32 = {shift_reg[23:0], GMII_RXD};
  assign word48 = {shift_reg[39:0], GMII_RXD};
  assign in_hdr = (state == S_ETH_HDR) || (state == S_IP_HDR) || (state == S_UDP_HDR);

  always_comb begin
    hdr_bad = 1'b0;
    case (state)
      S_ETH_HDR: hdr_bad = ((byte_cnt == 16'd5) && (word48 != LOCAL_MAC) && (word48 != {48{1'b1}})) ||
                           ((byte_cnt == 16'd13) && (word16 != 16'h0800));
      S_IP_HDR:  hdr_bad = ((byte_cnt == 16'd0) && (GMII_RXD != 8'h45)) ||
                           ((byte_cnt == 16'd9) && (GMII_RXD != 8'h11)) ||
                           ((byte_cnt == 16'd19) && (word32 != LOCAL_IP));
      S_UDP_HDR: hdr_bad = ((byte_cnt == 16'd3) && (word16 != LOCAL_PORT)) ||
                           ((byte_cnt == 16'd5) && (word16 < 16'd8));
      default:   hdr_bad = 1'b0;
    endcase
  end

  assign drop_event = in_hdr && (!GMII_RXDV || GMII_RXER || hdr_bad);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      byte_cnt      <= '0;
      remain        <= '0;
      shift_reg     <= '0;
      cap_src_ip    <= '0;
      cap_src_port  <= '0;
      rxdv_q        <= 1'b1;
      payload_data  <= '0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      src_ip        <= '0;
      src_port      <= '0;
      drop_cnt      <= '0;
    end else begin
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      // rxdv_q starts high after reset so a frame already in flight is never picked up.
      rxdv_q        <= GMII_RXDV;
      if (GMII_RXDV) shift_reg <= {shift_reg[31:0], GMII_RXD};
      if (drop_event && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

      case (state)
        S_IDLE: begin
          if (GMII_RXDV)
            state <= (!rxdv_q && (GMII_RXD == 8'h55)) ? S_PREAMBLE : S_WAIT_END;
        end
        S_PREAMBLE: begin
          if (!GMII_RXDV)                state <= S_IDLE;
          else if (GMII_RXER)            state <= S_WAIT_END;
          else if (GMII_RXD == 8'hD5) begin
            state    <= S_ETH_HDR;
            byte_cnt <= '0;
          end else if (GMII_RXD != 8'h55) state <= S_WAIT_END;
        end
        S_ETH_HDR, S_IP_HDR, S_UDP_HDR: begin
          if (!GMII_RXDV) begin
            state <= S_IDLE;
          end else if (GMII_RXER || hdr_bad) begin
            state <= S_WAIT_END;
          end else begin
            byte_cnt <= byte_cnt + 16'd1;
            if ((state == S_ETH_HDR) && (byte_cnt == 16'd13)) begin
              state    <= S_IP_HDR;
              byte_cnt <= '0;
            end
            if (state == S_IP_HDR) begin
              if (byte_cnt == 16'd15) cap_src_ip <= word32;
              if (byte_cnt == 16'd19) begin
                state    <= S_UDP_HDR;
                byte_cnt <= '0;
              end
            end
            if (state == S_UDP_HDR) begin
              if (byte_cnt == 16'd1) cap_src_port <= word16;
              if (byte_cnt == 16'd5) remain <= word16 - 16'd8;
              if (byte_cnt == 16'd7) begin
                src_ip   <= cap_src_ip;
                src_port <= cap_src_port;
                byte_cnt <= '0;
                if (remain == 16'd0) begin
                  frame_ok <= 1'b1;
                  state    <= S_WAIT_END;
                end else begin
                  state <= S_PAYLOAD;
                end
              end
            end
          end
        end
        S_PAYLOAD: begin
          if (!GMII_RXDV) begin
            frame_err <= 1'b1;
            state     <= S_IDLE;
          end else if (GMII_RXER) begin
            frame_err <= 1'b1;
            state     <= S_WAIT_END;
          end else begin
            payload_valid <= 1'b1;
            payload_data  <= GMII_RXD;
            remain        <= remain - 16'd1;
            if (remain == 16'd1) begin
              payload_last <= 1'b1;
              frame_ok     <= 1'b1;
              state        <= S_WAIT_END;
            end
          end
        end
        S_WAIT_END: begin
          if (!GMII_RXDV) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
